// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline register fields in, stage controls out.
// Controller takes the master side; the pipeline datapath takes the slave side.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [REG_W-1:0] ex_rn;
  logic [REG_W-1:0] ex_rm;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memread;
  logic [REG_W-1:0] mem_rd;
  logic             mem_regwrite;
  logic [REG_W-1:0] wb_rd;
  logic             wb_regwrite;
  logic             branch_taken;
  logic             dmem_wait;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             bypass_a;
  logic             bypass_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    input  id_rn, id_rm, id_uses_rn, id_uses_rm,
    input  ex_rn, ex_rm, ex_rd, ex_memread,
    input  mem_rd, mem_regwrite,
    input  wb_rd, wb_regwrite,
    input  branch_taken, dmem_wait,
    output pc_en, ifid_en, idex_en,
    output exmem_en, memwb_en, idex_bubble,
    output ifid_flush, idex_flush, exmem_flush,
    output forward_a, forward_b,
    output bypass_a, bypass_b,
    output stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    output id_rn, id_rm, id_uses_rn, id_uses_rm,
    output ex_rn, ex_rm, ex_rd, ex_memread,
    output mem_rd, mem_regwrite,
    output wb_rd, wb_regwrite,
    output branch_taken, dmem_wait,
    input  pc_en, ifid_en, idex_en,
    input  exmem_en, memwb_en, idex_bubble,
    input  ifid_flush, idex_flush, exmem_flush,
    input  forward_a, forward_b,
    input  bypass_a, bypass_b,
    input  stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding, load-use stall, branch flush and dmem freeze control.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl #(
  parameter int REG_W           = 5,
  parameter int ZERO_REG        = 31,
  parameter int LU_STALL_CYCLES = 1,
  parameter int BR_STAGE        = 3,
  parameter int CNT_W           = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.master h
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);
  localparam bit MULTI  = LU_STALL_CYCLES > 1;
  localparam bit BR_MEM = BR_STAGE == 3;

  state_t     state;
  state_t     state_n;
  logic [2:0] lu_left;
  logic [2:0] left_n;

  logic       mem_ok;
  logic       wb_ok;
  logic       lu_hit;
  logic [1:0] fa;
  logic [1:0] fb;

  assign mem_ok = h.mem_regwrite && (h.mem_rd != ZR);
  assign wb_ok  = h.wb_regwrite && (h.wb_rd != ZR);

  assign lu_hit = h.ex_memread && (h.ex_rd != ZR) &&
                  ((h.id_uses_rn && h.ex_rd == h.id_rn) ||
                   (h.id_uses_rm && h.ex_rd == h.id_rm));

  // EX/MEM is the younger producer, so it beats WB
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (mem_ok && h.mem_rd == h.ex_rn)     fa = 2'b10;
    else if (wb_ok && h.wb_rd == h.ex_rn)  fa = 2'b01;
    if (mem_ok && h.mem_rd == h.ex_rm)     fb = 2'b10;
    else if (wb_ok && h.wb_rd == h.ex_rm)  fb = 2'b01;
  end

  assign h.forward_a = rst ? fa : 2'b00;
  assign h.forward_b = rst ? fb : 2'b00;
  assign h.bypass_a  = rst && wb_ok && (h.wb_rd == h.id_rn);
  assign h.bypass_b  = rst && wb_ok && (h.wb_rd == h.id_rm);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      lu_left <= '0;
    end else begin
      state   <= state_n;
      lu_left <= left_n;
    end
  end

  always_comb begin
    state_n       = state;
    left_n        = lu_left;
    h.pc_en       = 1'b1;
    h.ifid_en     = 1'b1;
    h.idex_en     = 1'b1;
    h.exmem_en    = 1'b1;
    h.memwb_en    = 1'b1;
    h.idex_bubble = 1'b0;
    h.ifid_flush  = 1'b0;
    h.idex_flush  = 1'b0;
    h.exmem_flush = 1'b0;
    if (!rst) begin
      state_n = RUN;
      left_n  = '0;
    end else if (h.dmem_wait) begin
      h.pc_en    = 1'b0;
      h.ifid_en  = 1'b0;
      h.idex_en  = 1'b0;
      h.exmem_en = 1'b0;
      h.memwb_en = 1'b0;
    end else if (h.branch_taken) begin
      h.ifid_flush  = 1'b1;
      h.idex_flush  = 1'b1;
      h.exmem_flush = BR_MEM;
      state_n       = RUN;
      left_n        = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (lu_hit) begin
            h.pc_en       = 1'b0;
            h.ifid_en     = 1'b0;
            h.idex_bubble = 1'b1;
            if (MULTI) begin
              state_n = LU_STALL;
              left_n  = LU_INIT;
            end
          end
        end
        LU_STALL: begin
          h.pc_en       = 1'b0;
          h.ifid_en     = 1'b0;
          h.idex_bubble = 1'b1;
          left_n        = lu_left - 3'd1;
          if (lu_left == 3'd1) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic [CNT_W-1:0] freeze_q;
  logic             freeze_cyc;

  assign freeze_cyc = rst && h.dmem_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (h.idex_bubble && stall_q != CMAX)
        stall_q <= stall_q + CNT_W'(1);
      if (h.ifid_flush && flush_q != CMAX)
        flush_q <= flush_q + CNT_W'(1);
      if (freeze_cyc && freeze_q != CMAX)
        freeze_q <= freeze_q + CNT_W'(1);
    end
  end

  assign h.stall_cnt  = stall_q;
  assign h.flush_cnt  = flush_q;
  assign h.freeze_cnt = freeze_q;
`else
  assign h.stall_cnt  = {CNT_W{1'b0}};
  assign h.flush_cnt  = {CNT_W{1'b0}};
  assign h.freeze_cnt = {CNT_W{1'b0}};
`endif

endmodule
